// File: rtl/rr_packet_arbiter_if.sv
// Handshake bundle between the per-input VC buffers and the output-port arbiter.
// The arbiter attaches through the slave modport, the buffer/crossbar side through master.
interface rr_packet_arbiter_if #(
    parameter int NUM_REQ = 5,
    parameter int IDX_W   = 3
);
    logic [NUM_REQ-1:0] request;
    logic [NUM_REQ-1:0] tail;
    logic               out_ready;
    logic               grant_valid;
    logic [NUM_REQ-1:0] grant_onehot;
    logic [IDX_W-1:0]   grant_idx;
    logic               xfer;

    modport master (
        output request, tail, out_ready,
        input  grant_valid, grant_onehot, grant_idx, xfer
    );

    modport slave (
        input  request, tail, out_ready,
        output grant_valid, grant_onehot, grant_idx, xfer
    );
endinterface

// File: rtl/rr_packet_arbiter.sv
// Round-robin output-port arbiter that can hold a grant from head to tail flit
// (wormhole locking) and re-arbitrates back-to-back without a bubble cycle.
module rr_packet_arbiter #(
    parameter int NUM_REQ = 5,
    parameter int IDX_W   = 3,
    parameter int LOCK_EN = 1
) (
    input logic                clk,
    input logic                reset,
    rr_packet_arbiter_if.slave bus
);
    localparam logic [IDX_W-1:0] INVALID = '1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   g_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [NUM_REQ-1:0] onehot_q;

    logic               req_g;
    logic               tail_g;
    logic               xfer_c;
    logic               release_c;
    logic [NUM_REQ-1:0] others_c;
    logic [IDX_W-1:0]   win_ptr_d;
    logic [IDX_W-1:0]   win_g_d;

    // First set bit after p, wrapping; p itself is examined last.
    function automatic logic [IDX_W-1:0] arb(input logic [NUM_REQ-1:0] req,
                                             input logic [IDX_W-1:0]   p);
        logic [IDX_W-1:0] win;
        logic             found;
        int               c;
        win   = INVALID;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = (int'(p) + k) % NUM_REQ;
            if (!found && req[c]) begin
                win   = IDX_W'(c);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // The one-hot register is zero when idle, so masking with it never indexes INVALID.
    assign req_g    = |(bus.request & onehot_q);
    assign tail_g   = |(bus.tail & onehot_q);
    assign others_c = bus.request & ~onehot_q;
    assign xfer_c   = (state_q == GRANT) & bus.out_ready & req_g;

    assign release_c = (LOCK_EN != 0) ? (xfer_c & tail_g) : (xfer_c | ~req_g);

    assign win_ptr_d = arb(bus.request, ptr_q);
    assign win_g_d   = arb(bus.request, g_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            g_q      <= INVALID;
            onehot_q <= '0;
            ptr_q    <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (|bus.request) begin
                        state_q  <= GRANT;
                        g_q      <= win_ptr_d;
                        onehot_q <= NUM_REQ'(1) << win_ptr_d;
                    end
                end
                GRANT: begin
                    if (release_c) begin
                        ptr_q <= g_q;
                        if (|others_c) begin
                            g_q      <= win_g_d;
                            onehot_q <= NUM_REQ'(1) << win_g_d;
                        end else if (!req_g) begin
                            state_q  <= IDLE;
                            g_q      <= INVALID;
                            onehot_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    g_q      <= INVALID;
                    onehot_q <= '0;
                end
            endcase
        end
    end

    assign bus.grant_valid  = (state_q == GRANT);
    assign bus.grant_onehot = onehot_q;
    assign bus.grant_idx    = g_q;
    assign bus.xfer         = xfer_c;
endmodule

// File: doc/rr_packet_arbiter.md
Name: rr_packet_arbiter

Overview:
- Parametrised round-robin arbiter for the router output port. It selects one of NUM_REQ input VC buffers and holds the grant for a whole packet, from head flit to tail flit, so wormhole ordering is preserved.
- Grant is registered and qualified by a downstream ready handshake.
- Sits between the per-input VC buffers and the output crossbar mux.
- Generalises the fixed 5-way FSM arbiter: any requester count, packet locking, backpressure, one-hot plus encoded grant.

Parameters:
- NUM_REQ, 5, number of requesters (N,S,E,W,L ordering for index 0..4 in the 5-port router).
- IDX_W, 3, width of encoded grant; must satisfy 2^IDX_W > NUM_REQ so all-ones is free as INVALID.
- LOCK_EN, 1, 1 = hold grant until tail flit transferred; 0 = re-arbitrate after every transferred flit.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- request  input  NUM_REQ  per-requester "flit available" (buffer not empty)
- tail  input  NUM_REQ  per-requester "front flit is tail"; only sampled for the granted index
- out_ready  input  1  downstream accepts a flit this cycle
- grant_valid  output  1  registered, a grant is active
- grant_onehot  output  NUM_REQ  registered one-hot grant; 0 when not valid
- grant_idx  output  IDX_W  registered encoded grant; all-ones (INVALID) when not valid
- xfer  output  1  combinational: grant_valid & out_ready & request[grant_idx]; pops the granted buffer

Behaviour:
- Reset (async, any cycle, including mid-packet):
  - grant_valid=0, grant_onehot=0, grant_idx=all-ones.
  - Priority pointer ptr=NUM_REQ-1, so requester 0 has highest priority first.
  - Any partially sent packet is abandoned; no held state survives.
- States:
  - IDLE: grant_valid=0.
  - GRANT: grant_valid=1, grant_idx=g.
- Arbitration function arb(request, ptr): first set bit searching ptr+1, ptr+2, … wrapping modulo NUM_REQ, ending at ptr itself. The pointer holder has lowest priority but can still win if it is the only requester.
- IDLE:
  - If any request bit is set at a clock edge, g <= arb(request, ptr) and the state becomes GRANT.
  - The grant is visible one cycle after the request (1-cycle latency). Otherwise stay IDLE.
- GRANT, release condition:
  - LOCK_EN=1: release = xfer & tail[g].
  - LOCK_EN=0: release = xfer, or request[g]=0 (requester vanished without transfer).
  - LOCK_EN=1 and request[g]=0: hold the grant (packet body still arriving, wormhole). xfer is 0 in those cycles.
- GRANT, on release at an edge:
  - ptr <= g.
  - If request with bit g masked out is nonzero, g <= arb(request, g) and stay in GRANT. This gives zero-bubble back-to-back packets with grant_valid continuously 1.
  - Else if request[g] is still 1, re-grant g.
  - Else go to IDLE.
- GRANT, no release: g, grant_onehot and grant_idx are unchanged regardless of other requests or out_ready=0 (stall).
- ptr updates only on release; it never changes while a grant is held.
- grant_onehot and grant_idx are always consistent: onehot = 1<<grant_idx when valid.
- out_ready=0 with tail present: no release, the grant is held.
- Exactly one xfer per transferred flit; xfer is never 1 while grant_valid=0.
- Indices ≥ NUM_REQ are never produced except INVALID.

Test Plan:
- Reset then idle, request=0 for 10 cycles -> grant_valid=0, grant_idx=7, grant_onehot=0, xfer=0 throughout.
- request=00100, 3-flit packet, tail on 3rd flit, out_ready=1 -> grant_idx=2 one cycle after request, 3 xfer pulses, IDLE next cycle after the tail xfer.
- request=11111, 1-flit packets (tail always 1), out_ready=1 -> grant_idx sequence 0,1,2,3,4,0 with grant_valid held 1 and no bubbles.
- LOCK_EN=1, grant on 1 mid-packet, request[0] and request[3] asserted, out_ready toggled 1/0, request[1] dropped 2 cycles -> grant_idx stays 1 until tail xfer, then 3, because ptr=1.
- LOCK_EN=0, request=00011 with 4-flit packets -> grant alternates 0,1,0,1 per flit; dropping request[1] while granted -> release to 0 next edge.
- Assert reset during the 2nd flit of a packet from requester 4 -> outputs INVALID/0 immediately (asynchronous); after deassert with request=10001 -> grant_idx=0 first.
